// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared constants and state encoding for the fetch/stall controller.
// Default multiply/divide latencies live here beside the reset fetch address.
package fetch_stall_ctrl_pkg;

   localparam int          MD_MULT_CYCLES = 5;
   localparam int          MD_DIV_CYCLES  = 10;
   localparam logic [31:0] PC_START       = 32'h0000_3000;
   localparam logic [31:0] STALL_CNT_MAX  = 32'hFFFF_FFFF;

   typedef enum logic {
      FSC_IDLE = 1'b0,
      FSC_BUSY = 1'b1
   } fsc_state_e;

endpackage

// File: rtl/md_busy_counter.sv
// Tracks the multi-cycle multiply/divide unit with a down-counter.
// md_busy/md_done are registered alongside the state so they match it exactly.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   FSC_IDLE | unit free, cnt = 0, next md_start is accepted
//   FSC_BUSY | unit computing, cnt = remaining cycles incl. this one
module md_busy_counter
   import fetch_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy,
   output logic md_done
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

   fsc_state_e       state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FSC_IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         case (state)
            FSC_IDLE: begin
               if (md_start) begin
                  state   <= FSC_BUSY;
                  cnt     <= md_is_div ? DIV_LD : MULT_LD;
                  md_busy <= 1'b1;
                  md_done <= md_is_div ? (DIV_LD == CNT_ONE) : (MULT_LD == CNT_ONE);
               end
            end
            FSC_BUSY: begin
               // A second md_start here is ignored; stall keeps it out of E.
               if (cnt == CNT_ONE) begin
                  state   <= FSC_IDLE;
                  cnt     <= '0;
                  md_busy <= 1'b0;
                  md_done <= 1'b0;
               end else begin
                  cnt     <= cnt - CNT_ONE;
                  md_done <= (cnt == CNT_TWO);
               end
            end
            default: begin
               state   <= FSC_IDLE;
               cnt     <= '0;
               md_busy <= 1'b0;
               md_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Merges the data-hazard stall with the mult/div busy stall, drives the
// IFU/pipeline-register enables and keeps a saturating stall-cycle counter.
module fetch_stall_ctrl
   import fetch_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_start,
   input  logic        md_is_div,
   input  logic        d_uses_md,
   input  logic        data_stall,
   output logic        md_busy,
   output logic        md_done,
   output logic        stall,
   output logic        ifu_en,
   output logic        d_reg_en,
   output logic        e_reg_clr,
   output logic [31:0] stall_cnt
);

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_counter (
      .clk       (clk),
      .reset     (reset),
      .md_start  (md_start),
      .md_is_div (md_is_div),
      .md_busy   (md_busy),
      .md_done   (md_done)
   );

   // Only HI/LO users wait on the unit; everything else flows past it.
   assign stall     = data_stall | ((md_start | md_busy) & d_uses_md);
   assign ifu_en    = ~stall;
   assign d_reg_en  = ~stall;
   assign e_reg_clr = stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != STALL_CNT_MAX)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Self-checking bench for fetch_stall_ctrl: directed scenarios plus random
// stimulus, all compared against a remaining-cycles reference model.
module tb_fetch_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset, md_start, md_is_div, d_uses_md, data_stall;
   logic        md_busy, md_done, stall, ifu_en, d_reg_en, e_reg_clr;
   logic [31:0] stall_cnt;

   int          checks = 0;
   int          errors = 0;
   int          rem    = 0;
   logic [31:0] m_cnt  = 32'd0;

   fetch_stall_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .md_start   (md_start),
      .md_is_div  (md_is_div),
      .d_uses_md  (d_uses_md),
      .data_stall (data_stall),
      .md_busy    (md_busy),
      .md_done    (md_done),
      .stall      (stall),
      .ifu_en     (ifu_en),
      .d_reg_en   (d_reg_en),
      .e_reg_clr  (e_reg_clr),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: drive, check outputs, advance one clock.
   task automatic cycle(input logic r, input logic s, input logic d,
                        input logic u, input logic ds);
      logic e_busy, e_done, e_stall;
      reset = r; md_start = s; md_is_div = d; d_uses_md = u; data_stall = ds;
      #1;
      e_busy  = (rem > 0);
      e_done  = (rem == 1);
      e_stall = ds | ((s | e_busy) & u);
      chk("md_busy",   {31'd0, md_busy},   {31'd0, e_busy});
      chk("md_done",   {31'd0, md_done},   {31'd0, e_done});
      chk("stall",     {31'd0, stall},     {31'd0, e_stall});
      chk("ifu_en",    {31'd0, ifu_en},    {31'd0, ~e_stall});
      chk("d_reg_en",  {31'd0, d_reg_en},  {31'd0, ~e_stall});
      chk("e_reg_clr", {31'd0, e_reg_clr}, {31'd0, e_stall});
      chk("stall_cnt", stall_cnt, m_cnt);
      @(posedge clk);
      if (r) begin
         rem   = 0;
         m_cnt = 32'd0;
      end else begin
         if (rem > 0) rem = rem - 1;
         else if (s)  rem = d ? 10 : 5;
         if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; md_start = 1'b0; md_is_div = 1'b0; d_uses_md = 1'b0; data_stall = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // reset with all inputs low
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("reset_cnt", stall_cnt, 32'd0);
      chk("reset_ifu", {31'd0, ifu_en}, 32'd1);

      // mult, independent D instruction: no stall
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
      chk("mult_cnt", stall_cnt, 32'd0);

      // div with dependent mfhi: 11 stall cycles
      cycle(0, 1, 1, 1, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0);
      chk("div_cnt", stall_cnt, 32'd11);
      cycle(0, 0, 0, 1, 0);

      // second start in last busy cycle is ignored
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      // start in first idle cycle is accepted back-to-back
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);

      // reset mid-div
      cycle(0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0);
      chk("rst_mid_cnt", stall_cnt, 32'd0);

      // data_stall overlapping md stall counts once per cycle
      cycle(0, 1, 0, 1, 1);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 1);
      chk("overlap_cnt", stall_cnt, 32'd3);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 600; i++)
         cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));

      // saturation
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      m_cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
      chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
      cycle(0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
